// File: rtl/axil_reg_bridge_mc.sv
// AXI4-Lite slave bridging to NUM_SLV register-file ports, one address window per port.
// Port i occupies byte addresses [i << SLV_ADDR_W, (i+1) << SLV_ADDR_W).
// Optional feature macro: AXIL_REG_DECERR_EN -- when defined, unmapped accesses
// answer with DECERR (2'b11); otherwise they answer OKAY with no side effect.
module axil_reg_bridge_mc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLV    = 4,
    parameter int SLV_ADDR_W = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                      reg_clk,
    input  logic                      reg_rst,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [ADDR_W-1:0]         s_axil_awaddr,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    input  logic [DATA_W-1:0]         s_axil_wdata,
    input  logic [DATA_W/8-1:0]       s_axil_wstrb,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    output logic [1:0]                s_axil_bresp,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    input  logic [ADDR_W-1:0]         s_axil_araddr,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [DATA_W-1:0]         s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic [NUM_SLV-1:0]        reg_en,
    output logic                      reg_we,
    output logic [DATA_W/8-1:0]       reg_be,
    output logic [SLV_ADDR_W-1:0]     reg_addr,
    output logic [DATA_W-1:0]         reg_din,
    input  logic [NUM_SLV*DATA_W-1:0] reg_dout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W  = $clog2(RD_LAT + 1);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_DECERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b11;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    // True when the address selects an existing port and nothing above the index is set
    function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (addr[SLV_ADDR_W +: IDX_W] == IDX_W'(i)) hit = 1'b1;
        end
        return hit && ((addr >> (SLV_ADDR_W + IDX_W)) == '0);
    endfunction

    function automatic logic [NUM_SLV-1:0] port_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_SLV-1:0] oh;
        for (int i = 0; i < NUM_SLV; i++) oh[i] = (idx == IDX_W'(i));
        return oh;
    endfunction

    logic                  ready_en_q, ready_en_d;
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_W-1:0]     aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_W-1:0]     w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  wr_issued_q, wr_issued_d;
    logic                  wr_map_q, wr_map_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  ar_busy_q, ar_busy_d;
    logic [ADDR_W-1:0]     ar_addr_q, ar_addr_d;
    logic                  rd_req_q, rd_req_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic                  rd_map_q, rd_map_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  prio_rd_q, prio_rd_d;
    logic [NUM_SLV-1:0]    reg_en_q, reg_en_d;
    logic                  reg_we_q, reg_we_d;
    logic [SLV_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]     reg_din_q, reg_din_d;
    logic [STRB_W-1:0]     reg_be_q, reg_be_d;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  wr_req, grant_wr, grant_rd;
    logic                  wr_mapped, rd_mapped;
    logic [DATA_W-1:0]     rd_slice;

    assign s_axil_awready = ready_en_q & ~aw_full_q & ~bvalid_q;
    assign s_axil_wready  = ready_en_q & ~w_full_q & ~bvalid_q;
    assign s_axil_arready = ready_en_q & ~ar_busy_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign reg_en         = reg_en_q;
    assign reg_we         = reg_we_q;
    assign reg_addr       = reg_addr_q;
    assign reg_din        = reg_din_q;
    assign reg_be         = reg_be_q;

    assign aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_hs  = s_axil_wvalid & s_axil_wready;
    assign b_hs  = bvalid_q & s_axil_bready;
    assign ar_hs = s_axil_arvalid & s_axil_arready;
    assign r_hs  = rvalid_q & s_axil_rready;

    assign wr_mapped = addr_mapped(aw_addr_q);
    assign rd_mapped = addr_mapped(ar_addr_q);

    // A write competes only once both holders are full and nothing of it is in flight yet.
    // Priority flips only on contested cycles: whichever type wins a collision yields the next one.
    assign wr_req   = aw_full_q & w_full_q & ~wr_issued_q & ~bvalid_q;
    assign grant_wr = wr_req & (~rd_req_q | ~prio_rd_q);
    assign grant_rd = rd_req_q & ~grant_wr;

    // Select the read-data slice of the port addressed by the outstanding read
    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (rd_idx_q == IDX_W'(i)) rd_slice = reg_dout[i*DATA_W +: DATA_W];
        end
    end

    // Next-state logic for holders, arbitration, register strobes and responses
    always_comb begin
        ready_en_d  = 1'b1;
        aw_full_d   = aw_full_q;
        aw_addr_d   = aw_addr_q;
        w_full_d    = w_full_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        wr_issued_d = 1'b0;
        wr_map_d    = wr_map_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        ar_busy_d   = ar_busy_q;
        ar_addr_d   = ar_addr_q;
        rd_req_d    = rd_req_q;
        rd_cnt_d    = rd_cnt_q;
        rd_map_d    = rd_map_q;
        rd_idx_d    = rd_idx_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        prio_rd_d   = prio_rd_q;
        reg_en_d    = '0;
        reg_we_d    = 1'b0;
        reg_addr_d  = '0;
        reg_din_d   = '0;
        reg_be_d    = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axil_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end

        if (wr_req && rd_req_q) prio_rd_d = grant_wr;

        if (grant_wr) begin
            wr_issued_d = 1'b1;
            wr_map_d    = wr_mapped;
            if (wr_mapped) begin
                reg_en_d   = port_onehot(aw_addr_q[SLV_ADDR_W +: IDX_W]);
                reg_we_d   = 1'b1;
                reg_addr_d = aw_addr_q[SLV_ADDR_W-1:0];
                reg_din_d  = w_data_q;
                reg_be_d   = w_strb_q;
            end
        end
        if (wr_issued_q) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_map_q ? RESP_OKAY : RESP_UNMAPPED;
        end
        if (b_hs) begin
            bvalid_d  = 1'b0;
            bresp_d   = 2'b00;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        if (ar_hs) begin
            ar_busy_d = 1'b1;
            ar_addr_d = s_axil_araddr;
            rd_req_d  = 1'b1;
        end
        if (grant_rd) begin
            rd_req_d = 1'b0;
            rd_cnt_d = CNT_W'(RD_LAT);
            rd_map_d = rd_mapped;
            rd_idx_d = ar_addr_q[SLV_ADDR_W +: IDX_W];
            if (rd_mapped) begin
                reg_en_d   = port_onehot(ar_addr_q[SLV_ADDR_W +: IDX_W]);
                reg_addr_d = ar_addr_q[SLV_ADDR_W-1:0];
            end
        end
        if (rd_cnt_q != '0) begin
            rd_cnt_d = rd_cnt_q - CNT_W'(1);
            if (rd_cnt_q == CNT_W'(1)) begin
                rvalid_d = 1'b1;
                rdata_d  = rd_map_q ? rd_slice : '0;
                rresp_d  = rd_map_q ? RESP_OKAY : RESP_UNMAPPED;
            end
        end
        if (r_hs) begin
            rvalid_d  = 1'b0;
            rdata_d   = '0;
            rresp_d   = 2'b00;
            ar_busy_d = 1'b0;
        end
    end

    // State register; reset aborts any transaction in flight without a response
    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            ready_en_q  <= 1'b0;
            aw_full_q   <= 1'b0;
            aw_addr_q   <= '0;
            w_full_q    <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            wr_issued_q <= 1'b0;
            wr_map_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            ar_busy_q   <= 1'b0;
            ar_addr_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_cnt_q    <= '0;
            rd_map_q    <= 1'b0;
            rd_idx_q    <= '0;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            prio_rd_q   <= 1'b0;
            reg_en_q    <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_din_q   <= '0;
            reg_be_q    <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            aw_full_q   <= aw_full_d;
            aw_addr_q   <= aw_addr_d;
            w_full_q    <= w_full_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            wr_issued_q <= wr_issued_d;
            wr_map_q    <= wr_map_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            ar_busy_q   <= ar_busy_d;
            ar_addr_q   <= ar_addr_d;
            rd_req_q    <= rd_req_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_map_q    <= rd_map_d;
            rd_idx_q    <= rd_idx_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            prio_rd_q   <= prio_rd_d;
            reg_en_q    <= reg_en_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_din_q   <= reg_din_d;
            reg_be_q    <= reg_be_d;
        end
    end

endmodule
